// File: rtl/aoc_day11_pkg.sv
// rtl/aoc_day11_pkg.sv - shared sizes, node/count types and walk FSM encoding for path_count_accumulator
package aoc_day11_pkg;

  localparam int MAX_NODES   = 1024;
  localparam int NODE_WIDTH  = 10;
  localparam int COUNT_WIDTH = 16;

  typedef logic [NODE_WIDTH-1:0]  node_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  // S_SRC_CHK and S_FINAL_RD absorb the one-cycle registered RAM read latency
  typedef enum logic [3:0] {
    S_CLEAR,
    S_WAIT_SORT,
    S_INIT,
    S_FETCH,
    S_RD_SRC,
    S_SRC_CHK,
    S_QUERY,
    S_REPLY,
    S_DST_RD,
    S_DST_WR,
    S_FINAL,
    S_FINAL_RD,
    S_RESULT,
    S_DONE
  } state_t;

endpackage

// File: rtl/count_ram.sv
// rtl/count_ram.sv - simple dual-port RAM, one write port and one registered read port, no reset on contents
module count_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/path_count_accumulator.sv
// rtl/path_count_accumulator.sv - buffers the topological order, then propagates path counts start->end
// PATH_COUNT_SATURATE_EN: when defined, count additions clamp at all-ones instead of wrapping.
module path_count_accumulator #(
  parameter int MAX_NODES   = aoc_day11_pkg::MAX_NODES,
  parameter int NODE_WIDTH  = aoc_day11_pkg::NODE_WIDTH,
  parameter int COUNT_WIDTH = aoc_day11_pkg::COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NODE_WIDTH-1:0]  start_node_idx,
  input  logic [NODE_WIDTH-1:0]  end_node_idx,
  input  logic                   start_end_nodes_valid,
  input  logic                   sorted_valid,
  input  logic [NODE_WIDTH-1:0]  sorted_node,
  input  logic                   sorted_done,
  output logic                   query_valid,
  output logic [NODE_WIDTH-1:0]  query_data,
  input  logic                   query_ready,
  input  logic                   reply_valid,
  input  logic [NODE_WIDTH-1:0]  reply_data,
  input  logic                   reply_last,
  input  logic                   reply_no_edges_found,
  output logic                   reply_ready,
  output logic                   result_valid,
  output logic [COUNT_WIDTH-1:0] result_data
);

  import aoc_day11_pkg::*;

  localparam logic [NODE_WIDTH:0]   PTR_MAX  = (NODE_WIDTH+1)'(MAX_NODES);
  localparam logic [NODE_WIDTH-1:0] CLR_LAST = NODE_WIDTH'(MAX_NODES - 1);

  state_t state, state_nxt;

  logic [NODE_WIDTH:0]     wr_ptr;
  logic [NODE_WIDTH:0]     rd_ptr;
  logic                    done_seen;
  logic [NODE_WIDTH-1:0]   start_q;
  logic [NODE_WIDTH-1:0]   end_q;
  logic [NODE_WIDTH-1:0]   clr_addr;
  logic [NODE_WIDTH-1:0]   cur;
  logic [NODE_WIDTH-1:0]   dst_q;
  logic                    last_q;
  logic [COUNT_WIDTH-1:0]  src_cnt;
  logic [COUNT_WIDTH-1:0]  result_q;

  logic                    order_we;
  logic [NODE_WIDTH-1:0]   order_rdata;
  logic                    cnt_we;
  logic [NODE_WIDTH-1:0]   cnt_waddr;
  logic [COUNT_WIDTH-1:0]  cnt_wdata;
  logic [NODE_WIDTH-1:0]   cnt_raddr;
  logic [COUNT_WIDTH-1:0]  cnt_rdata;

  logic                    src_skip;
  logic [COUNT_WIDTH:0]    sum_full;
  logic [COUNT_WIDTH-1:0]  add_res;

  assign order_we = sorted_valid && (wr_ptr < PTR_MAX);
  assign src_skip = (cnt_rdata == '0) || (cur == end_q);
  assign sum_full = {1'b0, cnt_rdata} + {1'b0, src_cnt};

`ifdef PATH_COUNT_SATURATE_EN
  assign add_res = sum_full[COUNT_WIDTH] ? '1 : sum_full[COUNT_WIDTH-1:0];
`else
  assign add_res = sum_full[COUNT_WIDTH-1:0];
`endif

  count_ram #(
    .DEPTH (MAX_NODES),
    .AW    (NODE_WIDTH),
    .DW    (NODE_WIDTH)
  ) u_order_ram (
    .clk   (clk),
    .we    (order_we),
    .waddr (wr_ptr[NODE_WIDTH-1:0]),
    .wdata (sorted_node),
    .raddr (rd_ptr[NODE_WIDTH-1:0]),
    .rdata (order_rdata)
  );

  count_ram #(
    .DEPTH (MAX_NODES),
    .AW    (NODE_WIDTH),
    .DW    (COUNT_WIDTH)
  ) u_count_ram (
    .clk   (clk),
    .we    (cnt_we),
    .waddr (cnt_waddr),
    .wdata (cnt_wdata),
    .raddr (cnt_raddr),
    .rdata (cnt_rdata)
  );

  // Capture runs regardless of walk state so a sort finishing during CLEAR is not lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      done_seen <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
    end else begin
      if (order_we) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (sorted_done) begin
        done_seen <= 1'b1;
      end
      if (start_end_nodes_valid) begin
        start_q <= start_node_idx;
        end_q   <= end_node_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CLEAR:     if (clr_addr == CLR_LAST) state_nxt = S_WAIT_SORT;
      S_WAIT_SORT: if (done_seen) state_nxt = S_INIT;
      S_INIT:      state_nxt = S_FETCH;
      S_FETCH:     state_nxt = (rd_ptr == wr_ptr) ? S_FINAL : S_RD_SRC;
      S_RD_SRC:    state_nxt = S_SRC_CHK;
      S_SRC_CHK:   state_nxt = src_skip ? S_FETCH : S_QUERY;
      S_QUERY:     if (query_ready) state_nxt = S_REPLY;
      S_REPLY: begin
        if (reply_valid) begin
          state_nxt = reply_no_edges_found ? S_FETCH : S_DST_RD;
        end
      end
      S_DST_RD:    state_nxt = S_DST_WR;
      S_DST_WR:    state_nxt = last_q ? S_FETCH : S_REPLY;
      S_FINAL:     state_nxt = S_FINAL_RD;
      S_FINAL_RD:  state_nxt = S_RESULT;
      S_RESULT:    state_nxt = S_DONE;
      S_DONE:      state_nxt = S_DONE;
      default:     state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    query_valid  = (state == S_QUERY);
    query_data   = (state == S_QUERY) ? cur : '0;
    reply_ready  = (state == S_REPLY);
    result_valid = (state == S_RESULT);
    result_data  = result_q;
    cnt_we       = 1'b0;
    cnt_waddr    = clr_addr;
    cnt_wdata    = '0;
    cnt_raddr    = '0;
    unique case (state)
      S_CLEAR:  cnt_we = 1'b1;
      S_INIT: begin
        cnt_we    = 1'b1;
        cnt_waddr = start_q;
        cnt_wdata = COUNT_WIDTH'(1);
      end
      S_RD_SRC: cnt_raddr = order_rdata;
      S_DST_RD: cnt_raddr = dst_q;
      S_DST_WR: begin
        cnt_we    = 1'b1;
        cnt_waddr = dst_q;
        cnt_wdata = add_res;
      end
      S_FINAL:  cnt_raddr = end_q;
      default:  cnt_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_addr <= '0;
      rd_ptr   <= '0;
      cur      <= '0;
      dst_q    <= '0;
      last_q   <= 1'b0;
      src_cnt  <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        S_CLEAR:  clr_addr <= clr_addr + 1'b1;
        S_INIT:   rd_ptr <= '0;
        S_RD_SRC: cur <= order_rdata;
        S_SRC_CHK: begin
          src_cnt <= cnt_rdata;
          if (src_skip) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        S_REPLY: begin
          if (reply_valid) begin
            if (reply_no_edges_found) begin
              rd_ptr <= rd_ptr + 1'b1;
            end else begin
              dst_q  <= reply_data;
              last_q <= reply_last;
            end
          end
        end
        S_DST_WR: begin
          if (last_q) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        S_FINAL_RD: result_q <= cnt_rdata;
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_count_accumulator.sv
// tb/tb_path_count_accumulator.sv - directed bench for path_count_accumulator with an adjacency responder
module tb_path_count_accumulator;

  localparam int NW = 10;
  localparam int CW = 4;

`ifdef PATH_COUNT_SATURATE_EN
  localparam int CHAIN_EXP = 15;
`else
  localparam int CHAIN_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NW-1:0] start_node_idx = '0;
  logic [NW-1:0] end_node_idx = '0;
  logic          start_end_nodes_valid = 1'b0;
  logic          sorted_valid = 1'b0;
  logic [NW-1:0] sorted_node = '0;
  logic          sorted_done = 1'b0;
  logic          query_valid;
  logic [NW-1:0] query_data;
  logic          query_ready;
  logic          reply_valid;
  logic [NW-1:0] reply_data;
  logic          reply_last;
  logic          reply_no_edges_found;
  logic          reply_ready;
  logic          result_valid;
  logic [CW-1:0] result_data;

  int total = 0;
  int bad = 0;

  int nsucc [1024];
  int succ  [1024][2];
  int order_q [$];
  int hold_cycles = 0;
  bit hold_seen = 1'b0;
  bit busy = 1'b0;
  int rnode;
  int ridx;

  always #5 clk = ~clk;

  path_count_accumulator #(
    .COUNT_WIDTH (CW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start_node_idx        (start_node_idx),
    .end_node_idx          (end_node_idx),
    .start_end_nodes_valid (start_end_nodes_valid),
    .sorted_valid          (sorted_valid),
    .sorted_node           (sorted_node),
    .sorted_done           (sorted_done),
    .query_valid           (query_valid),
    .query_data            (query_data),
    .query_ready           (query_ready),
    .reply_valid           (reply_valid),
    .reply_data            (reply_data),
    .reply_last            (reply_last),
    .reply_no_edges_found  (reply_no_edges_found),
    .reply_ready           (reply_ready),
    .result_valid          (result_valid),
    .result_data           (result_data)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void clear_graph();
    foreach (nsucc[i]) nsucc[i] = 0;
  endfunction

  function automatic void add_edge(input int a, input int b);
    succ[a][nsucc[a]] = b;
    nsucc[a]++;
  endfunction

  function automatic void set_diamond();
    clear_graph();
    add_edge(0, 1);
    add_edge(0, 2);
    add_edge(1, 3);
    add_edge(2, 3);
    order_q = {0, 1, 2, 3};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Adjacency responder: decides drives at each falling edge; DUT ready/valid are stable then
  initial begin
    query_ready = 1'b0;
    reply_valid = 1'b0;
    reply_data = '0;
    reply_last = 1'b0;
    reply_no_edges_found = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        query_ready = 1'b0;
        reply_valid = 1'b0;
        reply_last = 1'b0;
        reply_no_edges_found = 1'b0;
        busy = 1'b0;
        continue;
      end
      if (busy) begin
        query_ready = 1'b0;
        reply_valid = 1'b1;
        if (nsucc[rnode] == 0) begin
          reply_data = '0;
          reply_last = 1'b1;
          reply_no_edges_found = 1'b1;
        end else begin
          reply_data = NW'(succ[rnode][ridx]);
          reply_last = (ridx == nsucc[rnode] - 1);
          reply_no_edges_found = 1'b0;
        end
        if (reply_ready) begin
          ridx++;
          if (reply_last) busy = 1'b0;
        end
      end else begin
        reply_valid = 1'b0;
        reply_last = 1'b0;
        reply_no_edges_found = 1'b0;
        reply_data = '0;
        if (hold_cycles > 0 && (query_valid || hold_seen)) begin
          query_ready = 1'b0;
          if (!hold_seen) begin
            hold_seen = 1'b1;
            chk("hold_first_node", int'(query_data), 0);
          end else begin
            chk("hold_qvalid", int'(query_valid), 1);
            chk("hold_qdata", int'(query_data), 0);
          end
          hold_cycles--;
        end else begin
          query_ready = query_valid;
          if (query_valid) begin
            busy = 1'b1;
            rnode = int'(query_data);
            ridx = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    sorted_valid = 1'b0;
    sorted_done = 1'b0;
    start_end_nodes_valid = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic launch(input int s, input int e, input bit strobe, input bit early);
    do_reset();
    if (strobe) begin
      start_node_idx = NW'(s);
      end_node_idx = NW'(e);
      start_end_nodes_valid = 1'b1;
      tick(1);
      start_end_nodes_valid = 1'b0;
    end else begin
      start_node_idx = NW'(1);
      end_node_idx = NW'(2);
    end
    if (!early) tick(1040);
    foreach (order_q[i]) begin
      sorted_valid = 1'b1;
      sorted_node = NW'(order_q[i]);
      tick(1);
    end
    sorted_valid = 1'b0;
    sorted_done = 1'b1;
    tick(1);
    sorted_done = 1'b0;
  endtask

  task automatic run_case(input string tag, input int s, input int e, input bit strobe,
                          input bit early, input int exp);
    bit seen;
    int got;
    int pulses;
    launch(s, e, strobe, early);
    seen = 1'b0;
    got = -1;
    pulses = 0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      tick(1);
      if (result_valid) begin
        seen = 1'b1;
        got = int'(result_data);
      end
    end
    chk({tag, "_seen"}, int'(seen), 1);
    chk({tag, "_data"}, got, exp);
    for (int c = 0; c < 5; c++) begin
      tick(1);
      if (result_valid) pulses++;
    end
    chk({tag, "_extra_pulses"}, pulses, 0);
  endtask

  initial begin
    bit seen;
    clear_graph();
    tick(2);
    chk("rst_query_valid", int'(query_valid), 0);
    chk("rst_query_data", int'(query_data), 0);
    chk("rst_reply_ready", int'(reply_ready), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result_data", int'(result_data), 0);

    set_diamond();
    run_case("diamond", 0, 3, 1'b1, 1'b0, 2);

    clear_graph();
    order_q = {5};
    run_case("start_eq_end", 5, 5, 1'b1, 1'b0, 1);

    clear_graph();
    add_edge(0, 1);
    order_q = {0, 1, 2};
    run_case("unreachable", 0, 2, 1'b1, 1'b0, 0);

    clear_graph();
    order_q = {};
    for (int k = 0; k < 5; k++) begin
      add_edge(3*k, 3*k + 1);
      add_edge(3*k, 3*k + 2);
      add_edge(3*k + 1, 3*k + 3);
      add_edge(3*k + 2, 3*k + 3);
    end
    for (int n = 0; n < 16; n++) order_q.push_back(n);
    run_case("chain32", 0, 15, 1'b1, 1'b0, CHAIN_EXP);

    set_diamond();
    hold_seen = 1'b0;
    hold_cycles = 10;
    run_case("hold", 0, 3, 1'b1, 1'b0, 2);
    chk("hold_consumed", hold_cycles, 0);

    set_diamond();
    run_case("done_in_clear", 0, 3, 1'b1, 1'b1, 2);

    clear_graph();
    order_q = {};
    run_case("empty_eq", 4, 4, 1'b1, 1'b0, 1);
    run_case("empty_ne", 1, 2, 1'b1, 1'b0, 0);
    run_case("no_strobe", 0, 0, 1'b0, 1'b0, 1);

    set_diamond();
    launch(0, 3, 1'b1, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      tick(1);
      if (reply_ready) seen = 1'b1;
    end
    chk("midrst_reply_seen", int'(seen), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_query_valid", int'(query_valid), 0);
    chk("midrst_query_data", int'(query_data), 0);
    chk("midrst_reply_ready", int'(reply_ready), 0);
    chk("midrst_result_valid", int'(result_valid), 0);
    chk("midrst_result_data", int'(result_data), 0);
    run_case("replay", 0, 3, 1'b1, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
